rm_event_detector_mc: RTL and testbench

//  Multi-channel runtime-monitor event detector. NUM_CH independent channels share one monitored

---
 rtl/rm_event_detector_mc_pkg.sv | 39 +++
 rtl/rm_event_detector_mc_if.sv | 31 +++
 rtl/rm_event_detector_mc_chan.sv | 107 ++++++++++
 rtl/rm_event_detector_mc.sv | 95 +++++++++
 tb/tb_rm_event_detector_mc.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rm_event_detector_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module : rm_event_detector_mc_pkg
// Brief  : Shared types for the multi-channel runtime-monitor event detector.
// Rev    : 1.0
// ============================================================================
package rm_event_detector_mc_pkg;

  // Index fields are wider than the default lane/itype counts so that
  // out-of-range encodings can be presented and rejected.
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned ITYPE_W    = 2;

  typedef enum logic [1:0] {
    RM_DET_LEVEL = 2'd0,
    RM_DET_PULSE = 2'd1,
    RM_DET_COUNT = 2'd2
  } rm_det_mode_e;

  typedef struct packed {
    logic                  monitor_ins;
    logic [LANE_IDX_W-1:0] lane0;
    logic [LANE_IDX_W-1:0] lane1;
    logic                  two_lane;
    logic [ITYPE_W-1:0]    itype;
  } runtime_monitor_ctrl;

  typedef struct packed {
    logic                  probe_val;
    logic                  reset_lane;
    logic                  reset_type;
    logic [LANE_IDX_W-1:0] lane0;
    logic [LANE_IDX_W-1:0] lane1;
    logic                  two_lane;
    logic [ITYPE_W-1:0]    itype;
  } lane_ctrl;

endpackage
`default_nettype wire

// File: rtl/rm_event_detector_mc_if.sv
`default_nettype none
// ============================================================================
// Module : rm_event_detector_mc_if
// Brief  : Monitored-signal / control stream and per-channel lane-control bus.
// Rev    : 1.0
// ============================================================================
interface rm_event_detector_mc_if
  import rm_event_detector_mc_pkg::*;
#(
  parameter int unsigned NUM_VARS          = 10,
  parameter int unsigned NUM_MONITORED_INS = 2,
  parameter int unsigned NUM_CH            = 4
);
  logic [NUM_VARS-1:0]          signal_i;
  runtime_monitor_ctrl          rm_cnt_i;
  logic                         reset_lane_i;
  logic                         leaf_reset_trigger;
  logic [NUM_MONITORED_INS-1:0] leaf_itype_mask_i;
  lane_ctrl [NUM_CH-1:0]        lane_cnt_o;

  modport master (
    output signal_i, rm_cnt_i, reset_lane_i, leaf_reset_trigger, leaf_itype_mask_i,
    input  lane_cnt_o
  );

  modport slave (
    input  signal_i, rm_cnt_i, reset_lane_i, leaf_reset_trigger, leaf_itype_mask_i,
    output lane_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/rm_event_detector_mc_chan.sv
`default_nettype none
// ============================================================================
// Module : rm_event_chan
// Brief  : One detection channel: masked match, per-lane armed bits/counters.
// Rev    : 1.0
// ============================================================================
module rm_event_chan
  import rm_event_detector_mc_pkg::*;
#(
  parameter int unsigned NUM_VARS  = 10,
  parameter int unsigned NUM_LANES = 5,
  parameter int unsigned CNT_W     = 4
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_ni,
  input  wire logic                  i_cfg_clr,
  input  wire logic                  i_monitor_ins,
  input  wire logic [NUM_VARS-1:0]   i_signal,
  input  wire logic [NUM_VARS-1:0]   i_ref_val,
  input  wire logic [NUM_VARS-1:0]   i_ref_mask,
  input  rm_det_mode_e               i_mode,
  input  wire logic [CNT_W-1:0]      i_cnt_thr,
  input  wire logic [LANE_IDX_W-1:0] i_lane0,
  input  wire logic [LANE_IDX_W-1:0] i_lane1,
  input  wire logic                  i_two_lane,
  input  wire logic                  i_reset_pulse,
  output logic                       o_probe
);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [NUM_LANES-1:0]            r_armed;
  logic [NUM_LANES-1:0][CNT_W-1:0] r_cnt;

  logic                 w_match;
  logic [NUM_LANES-1:0] w_tgt;
  logic                 w_lane0_ok;
  logic                 w_armed0;
  logic [CNT_W-1:0]     w_cnt0;
  logic [CNT_W-1:0]     w_thr;

  assign w_match = i_monitor_ins & (&(~i_ref_mask | ~(i_signal ^ i_ref_val)));
  assign w_thr   = (i_cnt_thr == '0) ? c_CNT_ONE : i_cnt_thr;

  // Lane decode; an index outside the lane range selects nothing.
  always_comb begin
    w_tgt      = '0;
    w_lane0_ok = 1'b0;
    w_armed0   = 1'b0;
    w_cnt0     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_lane0 == LANE_IDX_W'(l)) begin
        w_lane0_ok = 1'b1;
        w_armed0   = r_armed[l];
        w_cnt0     = r_cnt[l];
        w_tgt[l]   = 1'b1;
      end
      if (i_two_lane && (i_lane1 == LANE_IDX_W'(l))) begin
        w_tgt[l] = 1'b1;
      end
    end
    if (!i_monitor_ins) begin
      w_tgt = '0;
    end
  end

  always_comb begin
    o_probe = 1'b0;
    if (w_lane0_ok) begin
      case (i_mode)
        RM_DET_LEVEL: o_probe = w_match;
        RM_DET_PULSE: o_probe = w_match & ~w_armed0;
        RM_DET_COUNT: o_probe = w_match & (w_cnt0 != c_CNT_MAX) & ((w_cnt0 + c_CNT_ONE) == w_thr);
        default:      o_probe = 1'b0;
      endcase
    end
  end

  // Lane reset wins over a same-cycle arm or increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_armed <= '0;
      r_cnt   <= '0;
    end else if (i_cfg_clr) begin
      r_armed <= '0;
      r_cnt   <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_tgt[l]) begin
          if (i_reset_pulse) begin
            r_armed[l] <= 1'b0;
            r_cnt[l]   <= '0;
          end else begin
            if (i_mode == RM_DET_PULSE) begin
              r_armed[l] <= w_match;
            end
            if ((i_mode == RM_DET_COUNT) && w_match && (r_cnt[l] != c_CNT_MAX)) begin
              r_cnt[l] <= r_cnt[l] + c_CNT_ONE;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rm_event_detector_mc.sv
`default_nettype none
// ============================================================================
// Module : rm_event_detector_mc
// Brief  : Multi-channel runtime-monitor event detector with shared lane reset.
// Rev    : 1.0
// ============================================================================
module rm_event_detector_mc
  import rm_event_detector_mc_pkg::*;
#(
  parameter int unsigned NUM_VARS          = 10,
  parameter int unsigned NUM_LANES         = 5,
  parameter int unsigned NUM_MONITORED_INS = 2,
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned CNT_W             = 4,
  parameter bit          LEAF_EVENT        = 1'b0
) (
  input  wire logic                              clk_i,
  input  wire logic                              rst_ni,
  rm_event_detector_mc_if.slave                  mon,
  input  wire logic                              cfg_clr_i,
  input  wire logic [NUM_CH-1:0][NUM_VARS-1:0]   ref_val_i,
  input  wire logic [NUM_CH-1:0][NUM_VARS-1:0]   ref_mask_i,
  input  rm_det_mode_e [NUM_CH-1:0]              mode_i,
  input  wire logic [NUM_CH-1:0][CNT_W-1:0]      cnt_thr_i
);
  runtime_monitor_ctrl w_ctrl;
  logic                w_leaf_ok;
  logic                w_reset_val;
  logic                w_reset_pulse;
  logic                r_reset_q;
  logic [NUM_CH-1:0]   w_probe;

  assign w_ctrl = mon.rm_cnt_i;

  always_comb begin
    w_leaf_ok = 1'b0;
    for (int k = 0; k < NUM_MONITORED_INS; k++) begin
      if (w_ctrl.itype == ITYPE_W'(k)) begin
        w_leaf_ok = mon.leaf_itype_mask_i[k];
      end
    end
  end

  assign w_reset_val   = w_ctrl.monitor_ins &
                         (mon.reset_lane_i | (LEAF_EVENT & w_leaf_ok & mon.leaf_reset_trigger));
  assign w_reset_pulse = w_reset_val & ~r_reset_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reset_q <= 1'b0;
    end else if (cfg_clr_i) begin
      r_reset_q <= 1'b0;
    end else begin
      r_reset_q <= w_reset_val;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    rm_event_chan #(
      .NUM_VARS  (NUM_VARS),
      .NUM_LANES (NUM_LANES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .i_cfg_clr     (cfg_clr_i),
      .i_monitor_ins (w_ctrl.monitor_ins),
      .i_signal      (mon.signal_i),
      .i_ref_val     (ref_val_i[c]),
      .i_ref_mask    (ref_mask_i[c]),
      .i_mode        (mode_i[c]),
      .i_cnt_thr     (cnt_thr_i[c]),
      .i_lane0       (w_ctrl.lane0),
      .i_lane1       (w_ctrl.lane1),
      .i_two_lane    (w_ctrl.two_lane),
      .i_reset_pulse (w_reset_pulse),
      .o_probe       (w_probe[c])
    );
  end

  // Event outputs are forced low while reset is asserted.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mon.lane_cnt_o[c].probe_val  = rst_ni & w_probe[c];
      mon.lane_cnt_o[c].reset_lane = rst_ni & w_reset_pulse;
      mon.lane_cnt_o[c].reset_type = rst_ni & w_ctrl.monitor_ins & mon.reset_lane_i;
      mon.lane_cnt_o[c].lane0      = w_ctrl.lane0;
      mon.lane_cnt_o[c].lane1      = w_ctrl.lane1;
      mon.lane_cnt_o[c].two_lane   = w_ctrl.two_lane;
      mon.lane_cnt_o[c].itype      = w_ctrl.itype;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rm_event_detector_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_rm_event_detector_mc
// Brief  : Directed self-checking bench for rm_event_detector_mc.
// Rev    : 1.0
// ============================================================================
module tb_rm_event_detector_mc;
  import rm_event_detector_mc_pkg::*;

  localparam int unsigned NV = 10;
  localparam int unsigned NC = 4;
  localparam logic [9:0]  c_M = 10'h155;
  localparam logic [9:0]  c_X = 10'h000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  rm_event_detector_mc_if #(.NUM_VARS(NV), .NUM_MONITORED_INS(2), .NUM_CH(NC)) mon ();

  logic                  cfg_clr_i;
  logic [NC-1:0][NV-1:0] ref_val_i;
  logic [NC-1:0][NV-1:0] ref_mask_i;
  rm_det_mode_e [NC-1:0] mode_i;
  logic [NC-1:0][3:0]    cnt_thr_i;

  rm_event_detector_mc #(
    .NUM_VARS(NV), .NUM_LANES(5), .NUM_MONITORED_INS(2),
    .NUM_CH(NC), .CNT_W(4), .LEAF_EVENT(1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .mon        (mon.slave),
    .cfg_clr_i  (cfg_clr_i),
    .ref_val_i  (ref_val_i),
    .ref_mask_i (ref_mask_i),
    .mode_i     (mode_i),
    .cnt_thr_i  (cnt_thr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply(input logic mi, input logic [2:0] l0, input logic [2:0] l1,
                       input logic two, input logic [1:0] it, input logic [9:0] sig);
    mon.rm_cnt_i.monitor_ins = mi;
    mon.rm_cnt_i.lane0       = l0;
    mon.rm_cnt_i.lane1       = l1;
    mon.rm_cnt_i.two_lane    = two;
    mon.rm_cnt_i.itype       = it;
    mon.signal_i             = sig;
    #1;
  endtask

  task automatic clr();
    cfg_clr_i = 1'b1;
    apply(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, c_X);
    tick();
    cfg_clr_i = 1'b0;
  endtask

  initial begin
    cfg_clr_i                  = 1'b0;
    mon.reset_lane_i           = 1'b0;
    mon.leaf_reset_trigger     = 1'b0;
    mon.leaf_itype_mask_i      = 2'b10;
    ref_val_i                  = '{10'h3FF, 10'h3FF, c_M, c_M};
    ref_mask_i                 = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    mode_i                     = '{RM_DET_LEVEL, RM_DET_LEVEL, RM_DET_LEVEL, RM_DET_LEVEL};
    cnt_thr_i                  = '{4'd3, 4'd3, 4'd3, 4'd3};

    // Under reset a matching LEVEL channel must still present zero outputs.
    mon.reset_lane_i = 1'b1;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd0, c_M);
    check("rst_probe", mon.lane_cnt_o[0].probe_val, 0);
    check("rst_rlane", mon.lane_cnt_o[0].reset_lane, 0);
    check("rst_rtype", mon.lane_cnt_o[0].reset_type, 0);
    mon.reset_lane_i = 1'b0;
    apply(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, c_X);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // PULSE on lane 2
    mode_i[0] = RM_DET_PULSE;
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("pulse_1", mon.lane_cnt_o[0].probe_val, 1); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("pulse_2", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("pulse_3", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_X); check("pulse_miss", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("pulse_rearm", mon.lane_cnt_o[0].probe_val, 1); tick();
    apply(1'b0, 3'd2, 3'd0, 1'b0, 2'd0, c_X); check("pulse_nomon", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("pulse_held", mon.lane_cnt_o[0].probe_val, 0); tick();

    // COUNT thr=3 on lane 1, then lane reset and re-count
    mode_i[0] = RM_DET_COUNT;
    cnt_thr_i[0] = 4'd3;
    clr();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 3'd1, 3'd0, 1'b0, 2'd0, c_M);
      check($sformatf("cnt_a%0d", i), mon.lane_cnt_o[0].probe_val, (i == 2) ? 1 : 0);
      tick();
    end
    mon.reset_lane_i = 1'b1;
    apply(1'b1, 3'd1, 3'd0, 1'b0, 2'd0, c_M);
    check("cnt_rlane", mon.lane_cnt_o[0].reset_lane, 1);
    check("cnt_rtype", mon.lane_cnt_o[1].reset_type, 1);
    check("cnt_rprobe", mon.lane_cnt_o[0].probe_val, 0);
    tick();
    mon.reset_lane_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd1, 3'd0, 1'b0, 2'd0, c_M);
      check($sformatf("cnt_b%0d", i), mon.lane_cnt_o[0].probe_val, (i == 2) ? 1 : 0);
      tick();
    end

    // thr=0 behaves as 1 on lane 4; then saturation with thr=15 (cnt starts at 2)
    cnt_thr_i[0] = 4'd0;
    apply(1'b1, 3'd4, 3'd0, 1'b0, 2'd0, c_M); check("thr0_1", mon.lane_cnt_o[0].probe_val, 1); tick();
    apply(1'b1, 3'd4, 3'd0, 1'b0, 2'd0, c_M); check("thr0_2", mon.lane_cnt_o[0].probe_val, 0); tick();
    cnt_thr_i[0] = 4'd15;
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 3'd4, 3'd0, 1'b0, 2'd0, c_M);
      check($sformatf("sat_%0d", i), mon.lane_cnt_o[0].probe_val, (i == 12) ? 1 : 0);
      tick();
    end

    // Out-of-range lane index in LEVEL mode
    mode_i[0] = RM_DET_LEVEL;
    apply(1'b1, 3'd5, 3'd0, 1'b0, 2'd0, c_M); check("oor_5", mon.lane_cnt_o[0].probe_val, 0);
    apply(1'b1, 3'd7, 3'd0, 1'b0, 2'd0, c_M); check("oor_7", mon.lane_cnt_o[0].probe_val, 0);
    apply(1'b1, 3'd4, 3'd0, 1'b0, 2'd0, c_M); check("lvl_4", mon.lane_cnt_o[0].probe_val, 1);
    tick();

    // Dual-lane PULSE arms both lanes
    mode_i[0] = RM_DET_PULSE;
    clr();
    apply(1'b1, 3'd0, 3'd3, 1'b1, 2'd0, c_M);
    check("two_probe", mon.lane_cnt_o[0].probe_val, 1);
    check("two_l1_pass", mon.lane_cnt_o[2].lane1, 3);
    check("two_flag_pass", mon.lane_cnt_o[2].two_lane, 1);
    tick();
    apply(1'b1, 3'd3, 3'd0, 1'b0, 2'd0, c_M); check("two_lane3", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd1, 3'd0, 1'b0, 2'd0, c_M); check("two_lane1", mon.lane_cnt_o[0].probe_val, 1); tick();

    // Leaf qualifier, itype mask 2'b10
    mon.leaf_reset_trigger = 1'b1;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd0, c_X); check("leaf_it0", mon.lane_cnt_o[0].reset_lane, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd1, c_X);
      check($sformatf("leaf_it1_%0d", i), mon.lane_cnt_o[0].reset_lane, (i == 0) ? 1 : 0);
      check($sformatf("leaf_type_%0d", i), mon.lane_cnt_o[0].reset_type, 0);
      tick();
    end
    mon.leaf_reset_trigger = 1'b0;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd1, c_X); check("leaf_rel", mon.lane_cnt_o[0].reset_lane, 0); tick();
    mon.leaf_reset_trigger = 1'b1;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd2, c_X); check("leaf_it2", mon.lane_cnt_o[0].reset_lane, 0); tick();
    mon.leaf_reset_trigger = 1'b0;

    // Don't-care mask on channel 1
    mode_i[0]     = RM_DET_LEVEL;
    ref_mask_i[1] = '0;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 2'd0, c_X);
    check("mask_ch0", mon.lane_cnt_o[0].probe_val, 0);
    check("mask_ch1", mon.lane_cnt_o[1].probe_val, 1);
    apply(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, c_X);
    check("mask_nomon", mon.lane_cnt_o[1].probe_val, 0);
    tick();

    // Async reset in the middle of a COUNT run
    mode_i[0]    = RM_DET_COUNT;
    cnt_thr_i[0] = 4'd3;
    clr();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("ar_pre0", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("ar_pre1", mon.lane_cnt_o[0].probe_val, 0); tick();
    apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M); check("ar_pre2", mon.lane_cnt_o[0].probe_val, 1);
    rst_ni = 1'b0;
    #1;
    check("ar_immediate", mon.lane_cnt_o[0].probe_val, 0);
    tick(); tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd2, 3'd0, 1'b0, 2'd0, c_M);
      check($sformatf("ar_post%0d", i), mon.lane_cnt_o[0].probe_val, (i == 2) ? 1 : 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
